ex_redirect_ctrl: RTL
=====================

// Module: ex_redirect_ctrl
// PURPOSE
//  Sequences exception/ERET flush and fetch redirect between wb_stage and pre-IF/inst_sram.
//  Captures the WB flush request and target PC, pulses a pipeline-wide flush, then holds a redirect until accepted.
//  Tracks in-flight inst_sram requests so stale responses are marked for discard.
//  Registers the interrupt-pending flag for the ID stage.
// PARAMETERS
//  MAX_OUTSTANDING  2  max in-flight inst_sram requests (addr_ok seen, data_ok not yet)
//  CNT_W            2  width of outstanding/discard counters; must hold MAX_OUTSTANDING
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous reset, active low
//  ws_handle_ex    in   1   WB exception or ERET commit this cycle
//  ex_pc           in   32  redirect target (EPC or 0xbfc00380), valid with ws_handle_ex
//  has_int         in   1   unmasked interrupt pending from CP0
//  inst_req        in   1   pre-IF request to inst_sram (ungated)
//  inst_addr_ok    in   1   inst_sram accepted request
//  inst_data_ok    in   1   inst_sram returned data
//  flush           out  1   one-cycle kill of all stage valids
//  req_mask        out  1   pre-IF must drop inst_req this cycle
//  redirect_valid  out  1   pre-IF must fetch redirect_pc
//  redirect_pc     out  32  captured target
//  inst_discard    out  1   current inst_data_ok is stale; IF drops it
//  int_req         out  1   registered interrupt request to ID
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; redirect_pc=0; counters 0.
//  - outstanding: +1 on inst_req&&inst_addr_ok, -1 on inst_data_ok, same cycle both -> unchanged;
//    saturates at MAX_OUTSTANDING; data_ok at 0 does not decrement.
//  - IDLE: on ws_handle_ex latch ex_pc->redirect_pc, discard_cnt<=next outstanding value
//    (includes a request accepted this cycle); go FLUSH. ws_handle_ex in other states ignored.
//  - FLUSH (1 cycle): flush=1, req_mask=1; -> REDIR.
//  - REDIR: redirect_valid=1 until inst_req&&inst_addr_ok (that request is the redirect fetch);
//    on accept -> DRAIN if discard_cnt (after this cycle's update) >0, else IDLE.
//  - DRAIN: waits for discard_cnt==0 then -> IDLE; req_mask=0, redirect_valid=0.
//  - inst_discard = inst_data_ok && discard_cnt!=0 in any state; discard_cnt decrements on it.
//    Responses are in order, so stale data always precedes redirect data.
//  - int_req: registered has_int, forced 0 while busy or in the cycle ws_handle_ex is seen.
//  - busy combinational from state; flush/redirect_valid/req_mask decoded from state, glitch-free.
//  - Reset mid-sequence: immediate return to IDLE, counters cleared, no residual outputs.
// CONFIGURATION
//  EX_REDIRECT_PERF_EN defined: adds output flush_count[31:0], +1 per FLUSH entry, wraps
//   0xffffffff->0, reset 0. Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Idle, no outstanding; ws_handle_ex, ex_pc=0xbfc00380 -> flush 1 cycle later, then
//    redirect_valid, redirect_pc=0xbfc00380; addr_ok next cycle -> IDLE, busy=0.
//  2 Two requests outstanding, then ws_handle_ex -> discard_cnt=2; first two data_ok flagged
//    inst_discard, third (redirect) not; DRAIN -> IDLE after second stale return.
//  3 ws_handle_ex same cycle as inst_req&&addr_ok with 1 outstanding -> discard_cnt=2.
//  4 Redirect held 5 cycles with addr_ok=0 -> redirect_valid/redirect_pc stable; second
//    ws_handle_ex (ex_pc=0x1234) during REDIR ignored, redirect_pc unchanged.
//  5 has_int=1 in IDLE -> int_req=1 next cycle; during FLUSH/REDIR int_req=0.
//  6 Assert resetn=0 during DRAIN -> all outputs 0 immediately; flush_count (PERF_EN) cleared.

Source files
------------

// File: rtl/ex_redirect_ctrl.sv
// ex_redirect_ctrl: exception/ERET flush and fetch-redirect sequencer with stale inst_sram response discard
// Optional build macro EX_REDIRECT_PERF_EN adds a 32-bit flush_count output.
module ex_redirect_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_handle_ex,
  input  logic [31:0] ex_pc,
  input  logic        has_int,
  input  logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        flush,
  output logic        req_mask,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        inst_discard,
  output logic        int_req,
  output logic        busy
`ifdef EX_REDIRECT_PERF_EN
  ,
  output logic [31:0] flush_count
`endif
);
  // One-hot-style encoding so each control output is a single state flop
  typedef enum logic [2:0] {IDLE = 3'b000, FLUSH = 3'b001, REDIR = 3'b010, DRAIN = 3'b100} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] outstanding, out_nxt, discard_cnt, disc_nxt;
  logic int_q, accept, inc, dec, start;
  assign accept = inst_req && inst_addr_ok;
  assign start = (state == IDLE) && ws_handle_ex;
  assign inc = accept && (outstanding != CNT_W'(MAX_OUTSTANDING));
  assign dec = inst_data_ok && (outstanding != '0);
  assign inst_discard = inst_data_ok && (discard_cnt != '0);
  assign flush = state[0];
  assign req_mask = state[0];
  assign redirect_valid = state[1];
  assign busy = state != IDLE;
  assign int_req = int_q && !busy && !ws_handle_ex;
  // Counter next values: a simultaneous accept and return cancel out
  always_comb begin
    out_nxt = (accept && !inst_data_ok) ? outstanding + CNT_W'(inc) :
              (dec && !accept) ? outstanding - CNT_W'(1) : outstanding;
    disc_nxt = start ? out_nxt : discard_cnt - CNT_W'(inst_discard);
  end
  // Sequencer next state; redirect leaves via DRAIN only while stale data remains
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ws_handle_ex ? FLUSH : IDLE;
      FLUSH:   state_nxt = REDIR;
      REDIR:   state_nxt = !accept ? REDIR : (disc_nxt != '0) ? DRAIN : IDLE;
      DRAIN:   state_nxt = (disc_nxt == '0) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // State, counters, captured target and interrupt flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      outstanding <= '0;
      discard_cnt <= '0;
      redirect_pc <= '0;
      int_q <= 1'b0;
    end else begin
      state <= state_nxt;
      outstanding <= out_nxt;
      discard_cnt <= disc_nxt;
      redirect_pc <= start ? ex_pc : redirect_pc;
      int_q <= has_int;
    end
  end
`ifdef EX_REDIRECT_PERF_EN
  // Count entries into FLUSH, wrapping naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) flush_count <= '0;
    else if (start) flush_count <= flush_count + 32'd1;
  end
`endif
endmodule
